usb_tx_packet_builder: RTL and testbench
========================================

Name: usb_tx_packet_builder

Overview:
- Upstream neighbour of the USB transmitter: assembles a complete USB data packet (SYNC, PID, payload, CRC16) and hands it one byte at a time to the serializer/NRZI stage.
- Payload is pulled from the Ethernet-side first-word-fall-through (FWFT) buffer.
- Paced entirely by the transmitter's byte requests.
- Ends the packet when the transmitter reports completion.

Parameters:
- MAX_PAYLOAD, 64, maximum payload bytes per packet; a larger payload_len is clamped to this value.
- LEN_W, 7, width of payload_len and of the internal byte counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- n_rst  in  1  reset; synchronous, active-high (1 = reset).
- start  in  1  one-cycle request to begin a packet; sampled only in IDLE.
- pid  in  4  PID code (e.g. DATA0 = 4'b0011, DATA1 = 4'b1011); latched on an accepted start.
- payload_len  in  LEN_W  payload byte count, 0..MAX_PAYLOAD; latched on an accepted start.
- fifo_data  in  8  head byte of the FWFT buffer; valid when fifo_empty = 0.
- fifo_empty  in  1  buffer empty flag.
- fifo_rd  out  1  pop strobe, combinational, one cycle per consumed payload byte.
- byte_req  in  1  one-cycle pulse from the transmitter: the current tx_byte is taken.
- tx_complete  in  1  pulse from the transmitter after the end-of-packet (EOP) has been driven.
- tx_byte  out  8  byte presented to the transmitter; registered.
- tx_ena  out  1  high from the first byte until the packet is finished.
- last_byte  out  1  high while tx_byte holds the final CRC byte.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the packet is finished.
- underrun  out  1  sticky error flag; cleared on the next accepted start.

Behaviour:
- States: IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, WAIT_END.
- Reset (n_rst = 1 at an edge):
  - State goes to IDLE.
  - Outputs: tx_byte = 0x00, tx_ena = 0, last_byte = 0, busy = 0, done = 0, underrun = 0, fifo_rd = 0.
  - CRC register = 0xFFFF.
  - Applies mid-packet too: the packet is abandoned with no done pulse.
- IDLE:
  - A start sampled at edge N → at N+1: state SYNC, tx_byte = 0x80, tx_ena = 1, busy = 1, underrun = 0, CRC = 0xFFFF.
  - Latency is one cycle. start in any other state is ignored.
- Handshake:
  - Each byte_req consumes the current tx_byte; the next byte is loaded on that same edge.
  - byte_req is ignored in IDLE and WAIT_END.
  - tx_byte is held stable between requests, for any number of cycles.
- Byte sequence and transitions:
  - SYNC --req--> PID: tx_byte = {~pid, pid}.
  - PID --req--> DATA if len > 0, else CRC_LO.
  - DATA:
    - Each req loads the next payload byte while payload bytes remain.
    - The req that consumes payload byte len moves to CRC_LO.
  - CRC_LO: tx_byte = ~crc[7:0].
  - CRC_HI: tx_byte = ~crc[15:8], last_byte = 1.
  - CRC_HI --req--> WAIT_END: last_byte = 0.
- Payload fetch (loads of payload bytes only):
  - fifo_rd = byte_req & (next byte is payload) & ~fifo_empty.
  - tx_byte <= fifo_data on the same edge.
- Underrun:
  - Occurs if fifo_empty = 1 when a payload byte must be loaded.
  - Response: load 0x00, fifo_rd = 0, set underrun, continue the packet.
  - The CRC covers the substituted 0x00.
- CRC16 (USB):
  - Reflected register, init 0xFFFF.
  - Per bit, LSB first: if crc[0] ^ bit then crc = (crc >> 1) ^ 0xA001, else crc = crc >> 1.
  - All 8 bits of a byte are folded in a single cycle when that payload byte is loaded into tx_byte.
  - Transmitted complemented, low byte first.
- Zero-length payload: CRC bytes are 0x00, 0x00.
- WAIT_END:
  - tx_ena stays 1.
  - On tx_complete → IDLE; tx_ena = 0, busy = 0, done = 1 for exactly one cycle.
  - tx_complete in any other state is ignored.
- Simultaneous events:
  - n_rst has priority over all inputs.
  - start and tx_complete in the same WAIT_END cycle: tx_complete is honoured, start is dropped.

Test Plan:
- Reset mid-packet: n_rst = 1 while in DATA → next cycle all outputs at reset values, fifo_rd = 0, no done; a following start produces 0x80 again.
- Zero-length DATA0: pid = 0011, len = 0, byte_req every 8 cycles → bytes 0x80, 0xC3, 0x00, 0x00; last_byte only on the final byte; done one cycle after tx_complete.
- CRC check: pid = 1011, len = 9, FIFO holds 0x31..0x39 → bytes 0x80, 0x4B, 0x31..0x39, 0xC8, 0xB4; exactly 9 fifo_rd pulses, each coincident with a byte_req.
- Underrun: len = 4, FIFO holds 2 bytes → bytes 3 and 4 sent as 0x00; underrun = 1 until the next start; only 2 fifo_rd pulses; CRC equals the 4-byte CRC including the zeros.
- Clamp and ignore: len = 100 → exactly 64 payload bytes sent; a start pulsed during DATA has no effect; byte_req pulses in WAIT_END do not change tx_byte.
- Irregular pacing: byte_req gaps of 1, 3 and 20 cycles → tx_byte stable across every gap; sequence identical to the regular-pacing case.

Source files
------------

// File: rtl/usb_tx_packet_builder.sv
`default_nettype none
// ============================================================================
//  Module   : usb_tx_packet_builder
//  Purpose  : Builds one USB data packet (SYNC, PID, payload, CRC16) and
//             presents it to the transmitter one byte at a time. The payload
//             is read from a first-word-fall-through buffer. Each byte
//             request from the transmitter advances the sequence by one byte.
//  Ports    : clk, n_rst (sync, active-high)  - clock / reset
//             start, pid, payload_len         - packet request (sampled in IDLE)
//             fifo_data, fifo_empty, fifo_rd  - FWFT payload buffer interface
//             byte_req, tx_complete           - transmitter handshake
//             tx_byte, tx_ena, last_byte      - byte stream to the transmitter
//             busy, done, underrun            - status
//  Revision : 1.0 - initial release
// ============================================================================
module usb_tx_packet_builder #(
    parameter int MAX_PAYLOAD = 64,
    parameter int LEN_W       = 7
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic [3:0]       pid,
    input  logic [LEN_W-1:0] payload_len,
    input  logic [7:0]       fifo_data,
    input  logic             fifo_empty,
    output logic             fifo_rd,
    input  logic             byte_req,
    input  logic             tx_complete,
    output logic [7:0]       tx_byte,
    output logic             tx_ena,
    output logic             last_byte,
    output logic             busy,
    output logic             done,
    output logic             underrun
);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_SYNC     = 3'd1;
    localparam logic [2:0] c_ST_PID      = 3'd2;
    localparam logic [2:0] c_ST_DATA     = 3'd3;
    localparam logic [2:0] c_ST_CRC_LO   = 3'd4;
    localparam logic [2:0] c_ST_CRC_HI   = 3'd5;
    localparam logic [2:0] c_ST_WAIT_END = 3'd6;

    localparam logic [LEN_W-1:0] c_MAX_LEN   = LEN_W'(MAX_PAYLOAD);
    localparam logic [15:0]      c_CRC_INIT  = 16'hFFFF;
    localparam logic [15:0]      c_CRC_POLY  = 16'hA001;
    localparam logic [7:0]       c_SYNC_BYTE = 8'h80;

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [7:0]       r_tx_byte;
    logic [15:0]      r_crc;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic [3:0]       r_pid;
    logic             r_underrun;
    logic             r_done;

    logic [LEN_W-1:0] w_len_clamped;
    logic             w_more_payload;
    logic             w_load_payload;
    logic [7:0]       w_payload_byte;
    logic [15:0]      w_crc_next;

    // Reflected USB CRC16, one whole byte folded in, LSB first.
    function automatic logic [15:0] f_crc16_byte(input logic [15:0] crc_in,
                                                 input logic [7:0]  data);
        logic [15:0] crc;
        crc = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (crc[0] ^ data[i]) begin
                crc = (crc >> 1) ^ c_CRC_POLY;
            end else begin
                crc = crc >> 1;
            end
        end
        return crc;
    endfunction

    assign w_len_clamped = (payload_len > c_MAX_LEN) ? c_MAX_LEN : payload_len;

    // r_cnt counts payload bytes already loaded into tx_byte.
    assign w_more_payload = ((r_state == c_ST_PID) && (r_len != '0)) ||
                            ((r_state == c_ST_DATA) && (r_cnt < r_len));
    assign w_load_payload = byte_req && w_more_payload;

    // An empty buffer at load time substitutes zero; the CRC covers that zero.
    assign w_payload_byte = fifo_empty ? 8'h00 : fifo_data;
    assign w_crc_next     = f_crc16_byte(r_crc, w_payload_byte);

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) w_next_state = c_ST_SYNC;
            end
            c_ST_SYNC: begin
                if (byte_req) w_next_state = c_ST_PID;
            end
            c_ST_PID: begin
                if (byte_req) w_next_state = (r_len != '0) ? c_ST_DATA : c_ST_CRC_LO;
            end
            c_ST_DATA: begin
                if (byte_req && !w_more_payload) w_next_state = c_ST_CRC_LO;
            end
            c_ST_CRC_LO: begin
                if (byte_req) w_next_state = c_ST_CRC_HI;
            end
            c_ST_CRC_HI: begin
                if (byte_req) w_next_state = c_ST_WAIT_END;
            end
            c_ST_WAIT_END: begin
                // tx_complete wins; a coincident start is simply not looked at.
                if (tx_complete) w_next_state = c_ST_IDLE;
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        tx_ena    = (r_state != c_ST_IDLE);
        busy      = (r_state != c_ST_IDLE);
        last_byte = (r_state == c_ST_CRC_HI);
        fifo_rd   = w_load_payload && !fifo_empty;
    end

    // ---------------------------------------------------------------- datapath
    // tx_byte always holds the byte the transmitter will take on its next
    // request, so every request loads the following byte on the same edge.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_tx_byte  <= 8'h00;
            r_crc      <= c_CRC_INIT;
            r_len      <= '0;
            r_cnt      <= '0;
            r_pid      <= 4'h0;
            r_underrun <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_tx_byte  <= c_SYNC_BYTE;
                        r_crc      <= c_CRC_INIT;
                        r_len      <= w_len_clamped;
                        r_cnt      <= '0;
                        r_pid      <= pid;
                        r_underrun <= 1'b0;
                    end
                end
                c_ST_SYNC: begin
                    if (byte_req) r_tx_byte <= {~r_pid, r_pid};
                end
                c_ST_PID, c_ST_DATA: begin
                    if (w_load_payload) begin
                        r_tx_byte <= w_payload_byte;
                        r_crc     <= w_crc_next;
                        r_cnt     <= r_cnt + 1'b1;
                        if (fifo_empty) r_underrun <= 1'b1;
                    end else if (byte_req) begin
                        r_tx_byte <= ~r_crc[7:0];
                    end
                end
                c_ST_CRC_LO: begin
                    if (byte_req) r_tx_byte <= ~r_crc[15:8];
                end
                c_ST_WAIT_END: begin
                    if (tx_complete) r_done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign tx_byte  = r_tx_byte;
    assign done     = r_done;
    assign underrun = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_packet_builder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_usb_tx_packet_builder
//  Purpose  : Self-checking bench for usb_tx_packet_builder. Stimulus pushes
//             the expected byte stream into a scoreboard queue; a monitor pops
//             and compares every time the transmitter model takes a byte.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_usb_tx_packet_builder;

    logic       clk = 1'b0;
    logic       n_rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] pid = 4'h0;
    logic [6:0] payload_len = 7'd0;
    logic [7:0] fifo_data = 8'hEE;
    logic       fifo_empty = 1'b1;
    logic       fifo_rd;
    logic       byte_req = 1'b0;
    logic       tx_complete = 1'b0;
    logic [7:0] tx_byte;
    logic       tx_ena;
    logic       last_byte;
    logic       busy;
    logic       done;
    logic       underrun;

    int n_checks = 0;
    int n_fail   = 0;
    int rd_count = 0;

    logic [7:0] exp_q[$];
    logic [7:0] fifo_q[$];
    bit         req_counted = 1'b1;

    always #5 clk = ~clk;

    usb_tx_packet_builder #(.MAX_PAYLOAD(64), .LEN_W(7)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .pid         (pid),
        .payload_len (payload_len),
        .fifo_data   (fifo_data),
        .fifo_empty  (fifo_empty),
        .fifo_rd     (fifo_rd),
        .byte_req    (byte_req),
        .tx_complete (tx_complete),
        .tx_byte     (tx_byte),
        .tx_ena      (tx_ena),
        .last_byte   (last_byte),
        .busy        (busy),
        .done        (done),
        .underrun    (underrun)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] crc_upd(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ 16'hA001;
            else             c = c >> 1;
        end
        return c;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------ monitor
    logic       sampled_rd = 1'b0;
    logic [7:0] prev_tx    = 8'h00;
    bit         prev_req   = 1'b0;
    bit         prev_start = 1'b0;
    bit         prev_valid = 1'b0;

    always @(negedge clk) begin
        logic [7:0] e;
        sampled_rd = fifo_rd;
        if (!n_rst && byte_req && req_counted) begin
            if (exp_q.size() == 0) begin
                chk("tx_byte_unexpected_req", 16'(tx_byte), 16'h0100);
            end else begin
                e = exp_q.pop_front();
                chk("tx_byte", 16'(tx_byte), 16'(e));
            end
        end
        if (fifo_rd) begin
            rd_count++;
            chk("fifo_rd_with_req", 16'(byte_req), 16'h1);
        end
        if (prev_valid && busy && !prev_req && !prev_start) begin
            chk("tx_byte_hold", 16'(tx_byte), 16'(prev_tx));
        end
        prev_tx    = tx_byte;
        prev_req   = byte_req;
        prev_start = start;
        prev_valid = !n_rst;
    end

    // ------------------------------------------------------------ FWFT buffer model
    always @(posedge clk) begin
        #2;
        if (sampled_rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = (fifo_q.size() == 0) ? 8'hEE : fifo_q[0];
    end

    // ------------------------------------------------------------ packet driver
    task automatic run_packet(input logic [3:0] p, input int len, input bit irregular,
                              input bit poke_start, input bit fixed_en,
                              input logic [15:0] fixed_crc_bytes);
        int         eff;
        int         avail;
        int         total;
        int         rd0;
        int         gap;
        int         exp_rd;
        logic [15:0] c;
        logic [7:0]  b;
        logic [7:0]  held;
        eff   = (len > 64) ? 64 : len;
        avail = fifo_q.size();
        rd0   = rd_count;
        c     = 16'hFFFF;
        exp_q.push_back(8'h80);
        exp_q.push_back({~p, p});
        for (int i = 0; i < eff; i++) begin
            b = (i < avail) ? fifo_q[i] : 8'h00;
            exp_q.push_back(b);
            c = crc_upd(c, b);
        end
        if (fixed_en) begin
            exp_q.push_back(fixed_crc_bytes[7:0]);
            exp_q.push_back(fixed_crc_bytes[15:8]);
        end else begin
            exp_q.push_back(~c[7:0]);
            exp_q.push_back(~c[15:8]);
        end
        total  = eff + 4;
        exp_rd = (avail < eff) ? avail : eff;

        pid         = p;
        payload_len = len[6:0];
        start       = 1'b1;
        step;
        start = 1'b0;
        chk("start_tx_byte", 16'(tx_byte), 16'h0080);
        chk("start_busy", 16'(busy), 16'h1);
        chk("start_tx_ena", 16'(tx_ena), 16'h1);
        chk("start_underrun_clear", 16'(underrun), 16'h0);

        for (int k = 0; k < total; k++) begin
            if (irregular) gap = (k % 3 == 0) ? 1 : ((k % 3 == 1) ? 3 : 20);
            else           gap = 7;
            repeat (gap) step;
            chk("last_byte", 16'(last_byte), 16'(k == total - 1));
            if (poke_start && k == 4) start = 1'b1;
            byte_req = 1'b1;
            step;
            byte_req = 1'b0;
            start    = 1'b0;
        end

        step;
        chk("wait_tx_ena", 16'(tx_ena), 16'h1);
        chk("wait_last_byte", 16'(last_byte), 16'h0);
        chk("wait_done", 16'(done), 16'h0);
        held        = tx_byte;
        req_counted = 1'b0;
        byte_req    = 1'b1;
        step;
        byte_req = 1'b0;
        step;
        byte_req = 1'b1;
        step;
        byte_req    = 1'b0;
        req_counted = 1'b1;
        chk("wait_req_ignored", 16'(tx_byte), 16'(held));
        chk("fifo_rd_count", 16'(rd_count - rd0), 16'(exp_rd));
        chk("underrun_flag", 16'(underrun), 16'(avail < eff));

        tx_complete = 1'b1;
        step;
        tx_complete = 1'b0;
        chk("done_pulse", 16'(done), 16'h1);
        chk("done_busy", 16'(busy), 16'h0);
        chk("done_tx_ena", 16'(tx_ena), 16'h0);
        step;
        chk("done_one_cycle", 16'(done), 16'h0);
        chk("scoreboard_drained", 16'(exp_q.size()), 16'h0);
    endtask

    task automatic fill(input int n, input logic [7:0] first, input logic [7:0] incr);
        logic [7:0] v;
        v = first;
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(v);
            v = v + incr;
        end
        step;
    endtask

    task automatic summary;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    endtask

    // ------------------------------------------------------------ main sequence
    initial begin
        n_rst = 1'b1;
        repeat (3) step;
        chk("rst_tx_byte", 16'(tx_byte), 16'h0000);
        chk("rst_tx_ena", 16'(tx_ena), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_last_byte", 16'(last_byte), 16'h0);
        chk("rst_done", 16'(done), 16'h0);
        chk("rst_underrun", 16'(underrun), 16'h0);
        chk("rst_fifo_rd", 16'(fifo_rd), 16'h0);
        n_rst = 1'b0;
        step;

        // Zero-length DATA0: complemented initial CRC is 0x0000.
        run_packet(4'b0011, 0, 1'b0, 1'b0, 1'b1, 16'h0000);

        // DATA1 with "123456789": USB CRC16 check value 0xB4C8, sent C8 then B4.
        fill(9, 8'h31, 8'h01);
        run_packet(4'b1011, 9, 1'b0, 1'b0, 1'b1, 16'hB4C8);

        // Underrun: four bytes requested, only two buffered.
        fill(2, 8'hA5, 8'hB5);
        run_packet(4'b0011, 4, 1'b0, 1'b0, 1'b0, 16'h0000);

        // Clamp to 64 with 70 bytes buffered; a start is pulsed during DATA.
        fill(70, 8'h01, 8'h07);
        run_packet(4'b1011, 100, 1'b0, 1'b1, 1'b0, 16'h0000);
        chk("clamp_fifo_left", 16'(fifo_q.size()), 16'd6);
        fifo_q.delete();
        step;

        // Reset in the middle of DATA, with a request on the reset edge.
        fill(5, 8'h10, 8'h01);
        pid         = 4'b0011;
        payload_len = 7'd5;
        exp_q.push_back(8'h80);
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h11);
        start = 1'b1;
        step;
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step;
            byte_req = 1'b1;
            step;
            byte_req = 1'b0;
        end
        chk("mid_busy_before_rst", 16'(busy), 16'h1);
        req_counted = 1'b0;
        n_rst       = 1'b1;
        byte_req    = 1'b1;
        step;
        n_rst = 1'b0;
        chk("midrst_tx_byte", 16'(tx_byte), 16'h0000);
        chk("midrst_tx_ena", 16'(tx_ena), 16'h0);
        chk("midrst_busy", 16'(busy), 16'h0);
        chk("midrst_last_byte", 16'(last_byte), 16'h0);
        chk("midrst_fifo_rd", 16'(fifo_rd), 16'h0);
        chk("midrst_done", 16'(done), 16'h0);
        byte_req    = 1'b0;
        req_counted = 1'b1;
        chk("midrst_scoreboard", 16'(exp_q.size()), 16'h0);
        exp_q.delete();
        fifo_q.delete();
        repeat (3) begin
            step;
            chk("midrst_no_done", 16'(done), 16'h0);
        end

        // Irregular pacing repeats the CRC-check packet.
        fill(9, 8'h31, 8'h01);
        run_packet(4'b1011, 9, 1'b1, 1'b0, 1'b1, 16'hB4C8);

        repeat (3) step;
        summary();
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        summary();
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
